// File: rtl/g11620_emu_pkg.sv
// Shared definitions for the G11620 sensor emulator: FSM states,
// pattern codes and the noise LFSR (seed, taps, step function).
package g11620_emu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INTEG   = 3'd1,
    ST_DELAY   = 3'd2,
    ST_READOUT = 3'd3,
    ST_EOS     = 3'd4
  } state_e;

  localparam logic [1:0] PAT_RAMP  = 2'd0;
  localparam logic [1:0] PAT_FLAT  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_SLOPE = 2'd3;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 -> state bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/g11620_lfsr16.sv
// 16-bit Fibonacci LFSR used as a video noise source; steps when en_i.
module g11620_lfsr16
  import g11620_emu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q;

  // Seeded on reset, advanced only while enabled
  always_ff @(posedge clk) begin
    if (!rst_n)    state_q <= LFSR_SEED;
    else if (en_i) state_q <= lfsr_next(state_q);
  end

  assign state_o = state_q;

endmodule

// File: rtl/g11620_sensor_emu.sv
// G11620 InGaAs linear sensor output-side emulator.
// Integration strobe in; AD_SP pulse, pixel video stream and EOS out.
// Optional noise: define G11620_EMU_NOISE_EN to add LFSR noise to the video.
module g11620_sensor_emu
  import g11620_emu_pkg::*;
#(
  parameter logic [8:0] PIX_NUM    = 9'd511,
  parameter logic [7:0] SP_DELAY   = 8'd4,
  parameter int         DATA_W     = 16,
  parameter int         NOISE_BITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reset_i,
  input  logic [1:0]        pattern_i,
  input  logic              clear_i,
  output logic              ad_sp_o,
  output logic              video_valid_o,
  output logic [DATA_W-1:0] video_data_o,
  output logic [8:0]        pix_idx_o,
  output logic              eos_o,
  output logic [31:0]       integ_len_o,
  output logic              overrun_o,
  output logic              busy_o
);

  localparam logic [DATA_W-1:0] DMAX = '1;

  state_e            state_q, state_d;
  logic [31:0]       integ_cnt_q, integ_cnt_d;
  logic [31:0]       integ_len_q, integ_len_d;
  logic [1:0]        pat_q, pat_d;
  logic [7:0]        dly_q, dly_d;
  logic [8:0]        pix_q, pix_d;
  logic              ad_sp_q, ad_sp_d;
  logic              valid_q, valid_d;
  logic              eos_q, eos_d;
  logic              ovr_q, ovr_d, ovr_set;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] pat_v, data_v;
  logic [NOISE_BITS-1:0] noise;

  function automatic logic [DATA_W-1:0] sat33(input logic [32:0] x);
    if (x > 33'(DMAX)) return DMAX;
    return x[DATA_W-1:0];
  endfunction

`ifdef G11620_EMU_NOISE_EN
  logic [15:0] lfsr_q, lfsr_nx;

  // Steps on every edge that presents a sample, so sample 0 sees seed+1 step
  g11620_lfsr16 u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (valid_d),
    .state_o (lfsr_q)
  );

  assign lfsr_nx = lfsr_next(lfsr_q);
  assign noise   = lfsr_nx[NOISE_BITS-1:0];
`else
  assign noise   = '0;
`endif

  // Sequencer: integration timing, AD_SP delay, readout, abort handling
  always_comb begin
    state_d     = state_q;
    integ_cnt_d = integ_cnt_q;
    integ_len_d = integ_len_q;
    pat_d       = pat_q;
    dly_d       = dly_q;
    pix_d       = pix_q;
    ad_sp_d     = 1'b0;
    valid_d     = 1'b0;
    eos_d       = 1'b0;
    ovr_set     = 1'b0;
    case (state_q)
      ST_IDLE: if (reset_i) begin
        state_d     = ST_INTEG;
        integ_cnt_d = 32'd1;
      end
      ST_INTEG: begin
        if (reset_i) begin
          if (integ_cnt_q != 32'hFFFF_FFFF) integ_cnt_d = integ_cnt_q + 32'd1;
        end else begin
          state_d     = ST_DELAY;
          integ_len_d = integ_cnt_q;
          pat_d       = pattern_i;
          dly_d       = 8'd1;
          ad_sp_d     = (SP_DELAY == 8'd1);
        end
      end
      ST_DELAY: begin
        if (reset_i) begin
          state_d     = ST_INTEG;
          integ_cnt_d = 32'd1;
        end else if (ad_sp_q) begin
          state_d = ST_READOUT;
          valid_d = 1'b1;
          pix_d   = '0;
        end else begin
          dly_d   = dly_q + 8'd1;
          ad_sp_d = ((dly_q + 8'd1) == SP_DELAY);
        end
      end
      ST_READOUT: begin
        if (reset_i) begin
          state_d     = ST_INTEG;
          integ_cnt_d = 32'd1;
          ovr_set     = 1'b1;
        end else if (pix_q == PIX_NUM) begin
          state_d = ST_EOS;
          eos_d   = 1'b1;
        end else begin
          pix_d   = pix_q + 9'd1;
          valid_d = 1'b1;
        end
      end
      ST_EOS: begin
        // EOS pulse is already out; a new strobe skips the IDLE cycle
        if (reset_i) begin
          state_d     = ST_INTEG;
          integ_cnt_d = 32'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ovr_d  = ovr_set | (ovr_q & ~clear_i);
    busy_d = (state_d != ST_IDLE);
  end

  // Video value for the sample about to be presented (pix_d, latched pattern)
  always_comb begin
    pat_v = '0;
    case (pat_q)
      PAT_RAMP:  pat_v = DATA_W'(pix_d);
      PAT_FLAT:  pat_v = sat33({1'b0, integ_len_q});
      PAT_CHECK: pat_v = pix_d[0] ? DMAX : '0;
      default:   pat_v = sat33({1'b0, integ_len_q} + 33'(pix_d));
    endcase
    data_v = sat33(33'(pat_v) + 33'(noise));
    data_d = valid_d ? data_v : '0;
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      integ_cnt_q <= '0;
      integ_len_q <= '0;
      pat_q       <= '0;
      dly_q       <= '0;
      pix_q       <= '0;
      ad_sp_q     <= 1'b0;
      valid_q     <= 1'b0;
      eos_q       <= 1'b0;
      ovr_q       <= 1'b0;
      busy_q      <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      integ_cnt_q <= integ_cnt_d;
      integ_len_q <= integ_len_d;
      pat_q       <= pat_d;
      dly_q       <= dly_d;
      pix_q       <= pix_d;
      ad_sp_q     <= ad_sp_d;
      valid_q     <= valid_d;
      eos_q       <= eos_d;
      ovr_q       <= ovr_d;
      busy_q      <= busy_d;
      data_q      <= data_d;
    end
  end

  assign ad_sp_o       = ad_sp_q;
  assign video_valid_o = valid_q;
  assign video_data_o  = data_q;
  assign pix_idx_o     = pix_q;
  assign eos_o         = eos_q;
  assign integ_len_o   = integ_len_q;
  assign overrun_o     = ovr_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_g11620_sensor_emu.sv
// Scoreboard bench for g11620_sensor_emu. Stimulus pushes the expected
// ad_sp / pixel / eos events (with their cycle stamps) into a queue; a
// negedge monitor pops and compares whenever the DUT shows an event.
// A 12-bit video width keeps the saturation scans short.
module tb_g11620_sensor_emu;

  localparam int PIX = 511;
  localparam int SP  = 4;
  localparam int DW  = 12;
  localparam int NB  = 4;

  localparam int K_SP  = 0;
  localparam int K_PIX = 1;
  localparam int K_EOS = 2;

  typedef struct {
    int     kind;
    int     cyc;
    int     pix;
    longint data;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          reset_i = 1'b0;
  logic [1:0]    pattern_i = 2'd0;
  logic          clear_i = 1'b0;
  logic          ad_sp_o, video_valid_o, eos_o, overrun_o, busy_o;
  logic [DW-1:0] video_data_o;
  logic [8:0]    pix_idx_o;
  logic [31:0]   integ_len_o;

  int  cyc = 0;
  int  n_vec = 0;
  int  n_err = 0;
  ev_t exp_q[$];
  int  lfsr_m = 16'hACE1;

  g11620_sensor_emu #(
    .PIX_NUM(9'(PIX)), .SP_DELAY(8'(SP)), .DATA_W(DW), .NOISE_BITS(NB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .reset_i(reset_i), .pattern_i(pattern_i),
    .clear_i(clear_i), .ad_sp_o(ad_sp_o), .video_valid_o(video_valid_o),
    .video_data_o(video_data_o), .pix_idx_o(pix_idx_o), .eos_o(eos_o),
    .integ_len_o(integ_len_o), .overrun_o(overrun_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference video value straight from the pattern rules
  function automatic longint exp_data(input int pat, input longint ilen,
                                      input int pix, input int noise);
    longint maxv, p;
    maxv = (64'd1 << DW) - 1;
    case (pat)
      0:       p = pix;
      1:       p = (ilen > maxv) ? maxv : ilen;
      2:       p = (pix % 2 == 1) ? maxv : 0;
      default: p = (ilen + pix > maxv) ? maxv : ilen + pix;
    endcase
    p = p + noise;
    return (p > maxv) ? maxv : p;
  endfunction

  function automatic int noise_step();
`ifdef G11620_EMU_NOISE_EN
    int fb;
    fb = ((lfsr_m >> 15) ^ (lfsr_m >> 13) ^ (lfsr_m >> 12) ^ (lfsr_m >> 10)) & 1;
    lfsr_m = ((lfsr_m << 1) | fb) & 16'hFFFF;
    return lfsr_m & ((1 << NB) - 1);
`else
    return 0;
`endif
  endfunction

  task automatic push(input int kind, input int c, input int pix, input longint d);
    ev_t e;
    e.kind = kind; e.cyc = c; e.pix = pix; e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every DUT event must match the head of the expectation queue
  task automatic take(input int kind, input int pix, input longint d);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected event kind %0d pix %0d at cyc %0d", kind, pix, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.pix != pix || e.data != d) begin
        n_err++;
        $display("FAIL event: got kind %0d cyc %0d pix %0d data %0d, expected kind %0d cyc %0d pix %0d data %0d",
                 kind, cyc, pix, d, e.kind, e.cyc, e.pix, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (ad_sp_o)       take(K_SP, 0, 0);
    if (video_valid_o) take(K_PIX, int'(pix_idx_o), longint'(video_data_o));
    if (eos_o)         take(K_EOS, 0, 0);
  end

  // One integration of n sampled-high edges followed by a readout.
  // abort_pix/rst_pix >= 0 cut the readout at that pixel; early returns
  // on the EOS cycle so the next strobe lands in EOS.
  task automatic run_scan(input int n, input int pat, input int abort_pix,
                          input int rst_pix, input int chg_pix, input int chg_pat,
                          input bit clr_abort, input bit early);
    int e0, last, t_stop, eos_c;
    reset_i   = 1'b1;
    pattern_i = 2'(pat);
    repeat (n) begin
      @(posedge clk); #1;
      clear_i = 1'b0;
    end
    reset_i = 1'b0;
    e0      = cyc + 1;
    eos_c   = e0 + SP + PIX + 1;
    last    = (abort_pix >= 0) ? abort_pix : (rst_pix >= 0) ? rst_pix : PIX;
    push(K_SP, e0 + SP - 1, 0, 0);
    for (int i = 0; i <= last; i++)
      push(K_PIX, e0 + SP + i, i, exp_data(pat, n, i, noise_step()));
    if (abort_pix < 0 && rst_pix < 0) push(K_EOS, eos_c, 0, 0);
    t_stop = (abort_pix >= 0) ? e0 + SP + abort_pix :
             (rst_pix >= 0)   ? e0 + SP + rst_pix :
             early            ? eos_c : eos_c + 1;
    while (cyc < t_stop) begin
      @(posedge clk); #1;
      if (chg_pix >= 0 && cyc == e0 + SP + chg_pix) pattern_i = 2'(chg_pat);
    end
    cmp("integ_len", integ_len_o, n);
    if (abort_pix >= 0) begin
      reset_i = 1'b1;
      clear_i = clr_abort;
    end else if (rst_pix >= 0) begin
      rst_n = 1'b0;
      @(posedge clk); #1;
      cmp("rst valid", video_valid_o, 0);
      cmp("rst ad_sp", ad_sp_o, 0);
      cmp("rst eos", eos_o, 0);
      cmp("rst busy", busy_o, 0);
      cmp("rst data", video_data_o, 0);
      cmp("rst pix", pix_idx_o, 0);
      cmp("rst integ_len", integ_len_o, 0);
      cmp("rst overrun", overrun_o, 0);
      rst_n  = 1'b1;
      lfsr_m = 16'hACE1;
    end else if (!early) begin
      cmp("busy after eos", busy_o, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    cmp("reset busy", busy_o, 0);
    cmp("reset integ_len", integ_len_o, 0);
    cmp("reset overrun", overrun_o, 0);
    cmp("reset valid", video_valid_o, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_scan(100, 0, -1, -1, -1, 0, 0, 0);    // ramp, timing
    run_scan(5000, 1, -1, -1, -1, 0, 0, 0);   // flat saturated
    run_scan(4090, 3, -1, -1, -1, 0, 0, 0);   // slope crossing saturation
    run_scan(37, 2, -1, -1, 10, 0, 0, 0);     // checker, pattern change ignored
    run_scan(1, 0, -1, -1, -1, 0, 0, 0);      // one-cycle strobe
    cmp("overrun idle", overrun_o, 0);

    run_scan(50, $urandom_range(0, 3), 200, -1, -1, 0, 0, 0);  // abort
    run_scan(20, 0, -1, -1, -1, 0, 0, 0);
    cmp("overrun set", overrun_o, 1);
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    cmp("overrun cleared", overrun_o, 0);

    run_scan(30, 3, 7, -1, -1, 0, 1, 0);      // abort with clear same edge
    run_scan(15, 2, -1, -1, -1, 0, 0, 1);     // next strobe lands in EOS
    run_scan(12, 1, -1, -1, -1, 0, 0, 0);
    cmp("overrun set beats clear", overrun_o, 1);
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;

    run_scan(60, 0, -1, 300, -1, 0, 0, 0);    // rst_n mid-readout
    run_scan(10, 3, -1, -1, -1, 0, 0, 0);

    for (int k = 0; k < 6; k++) begin
      int ch;
      ch = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, PIX)) : -1;
      run_scan($urandom_range(1, 300), $urandom_range(0, 3), -1, -1,
               ch, $urandom_range(0, 3), 0, ($urandom_range(0, 3) == 0));
    end

    repeat (5) @(posedge clk);
    #1;
    cmp("pending events", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/g11620_sensor_emu.md
Name: g11620_sensor_emu

Overview:
- Synthesizable emulator of the G11620 InGaAs linear sensor's output side. It responds to the acquisition controller's reset/integration strobe with an AD_SP start pulse, a pixel video stream and an end-of-scan pulse.
- Used for in-FPGA loopback bring-up and for closed-loop simulation of the acquisition controller without silicon.
- Runs on the controller clock; no CDC.

Parameters:
- PIX_NUM, 9'd511, index of last pixel; a scan is PIX_NUM+1 pixels.
- SP_DELAY, 8'd4, cycles from integration end to the ad_sp_o pulse; must be >= 1.
- DATA_W, 16, video sample width.
- NOISE_BITS, 4, LFSR bits added as noise (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- reset_i  in  1  sensor RESET from the controller; high = integrating
- pattern_i  in  2  test pattern select
- clear_i  in  1  clears sticky overrun_o
- ad_sp_o  out  1  start-of-readout pulse (the controller's ad_sp)
- video_valid_o  out  1  pixel sample valid
- video_data_o  out  DATA_W  pixel sample
- pix_idx_o  out  9  index of current pixel
- eos_o  out  1  end-of-scan pulse
- integ_len_o  out  32  length of last completed integration, in cycles
- overrun_o  out  1  sticky: readout aborted by new integration
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst_n), synchronous, active-low: all outputs 0, state IDLE, LFSR = 16'hACE1.
- State machine: IDLE, INTEG, DELAY, READOUT, EOS. All outputs are registered.
- IDLE:
  - reset_i sampled 1 -> INTEG, with integ_cnt = 1.
- INTEG:
  - While reset_i = 1: integ_cnt increments, saturating at 32'hFFFF_FFFF.
  - Let T0 be the first cycle reset_i is sampled 0. At T0: latch integ_len_o = integ_cnt, latch pattern_i into pat_r, dly_cnt = 1, go to DELAY.
- DELAY:
  - dly_cnt increments each cycle.
  - ad_sp_o = 1 for exactly one cycle, at cycle T0+SP_DELAY. With SP_DELAY = 1, ad_sp_o rises on the cycle after T0.
  - After the ad_sp_o cycle -> READOUT with pix_idx = 0.
- READOUT:
  - video_valid_o = 1 on PIX_NUM+1 consecutive cycles, first valid at T0+SP_DELAY+1.
  - pix_idx_o counts 0..PIX_NUM.
  - After pix_idx == PIX_NUM -> EOS.
- EOS:
  - eos_o = 1 for one cycle, then IDLE.
- Pattern, with sat(x) = min(x, 2^DATA_W-1):
  - 0: ramp, data = pix_idx zero-extended.
  - 1: flat, data = sat(integ_len).
  - 2: checker, data = 0 on even pix_idx, all-ones on odd.
  - 3: slope, data = sat(integ_len + pix_idx), computed at 33 bits before saturating.
  - pattern_i changes during a scan have no effect; pat_r is used.
- reset_i = 1 in DELAY or READOUT (abort):
  - Next state is INTEG with integ_cnt = 1.
  - video_valid_o and ad_sp_o drop the next cycle; no eos_o is issued.
  - overrun_o is set if the state was READOUT. A DELAY-phase abort does not set it.
- reset_i = 1 in EOS: eos_o is still issued, then INTEG. Same result as EOS -> IDLE -> INTEG, but one cycle earlier.
- overrun_o:
  - Stays 1 until clear_i is sampled 1.
  - If set and clear land in the same cycle, set wins.
- integ_len_o holds its value until the next integration end.
- A reset_i glitch of one cycle gives integ_len_o = 1 and a full readout.

Optional Feature:
- Macro: G11620_EMU_NOISE_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances once per READOUT cycle.
  - video_data_o = sat(pattern + LFSR[NOISE_BITS-1:0]).
  - The LFSR is held outside READOUT.
- Undefined:
  - No LFSR logic; video_data_o = pattern exactly.

Decomposition:
- Package g11620_emu_pkg holds:
  - state encodings (3-bit);
  - pattern codes PAT_RAMP/PAT_FLAT/PAT_CHECK/PAT_SLOPE;
  - LFSR_SEED 16'hACE1 and the tap mask.
- One sub-module, g11620_lfsr16, with inputs clk, rst_n, en and a 16-bit state output. It is instantiated only under G11620_EMU_NOISE_EN.

Test Plan:
- Integration capture and timing: reset_i high 100 cycles, pattern 0, SP_DELAY = 4 -> integ_len_o = 100; ad_sp_o single pulse at T0+4; 512 valid samples with data 0..511; eos_o one cycle after the last sample; busy_o low after.
- Flat and slope saturation: integ_len 70000, DATA_W 16 -> pattern 1 gives all samples 16'hFFFF. Integ_len 65530 with pattern 3 -> pixel 0 = 65530, pixel 5 onward = 65535.
- Checker, plus pattern change mid-scan: pattern_i switched 2 -> 0 at pixel 10 -> samples keep alternating 0/FFFF through pixel 511.
- Abort during readout: reset_i rises at pixel 200 -> valid drops next cycle, no eos_o, overrun_o = 1. Next scan completes normally; clear_i pulse -> overrun_o = 0. Simultaneous set and clear -> overrun_o = 1.
- rst_n mid-READOUT at pixel 300 -> all outputs 0 the next cycle, state IDLE; the following integration of 10 cycles gives integ_len_o = 10.
- Noise on: noise feature compiled in, pattern 0 -> first sample = 0 + (16'hACE1 advanced once)[3:0]; sample sequence matches the reference LFSR model. Same scan with the feature compiled out -> exact ramp.
